// File: rtl/bus_control_sequencer.sv
// Instruction sequencer for the common-bus basic computer: walks fetch, decode,
// indirect and execute phases and decodes bus/strobe/ALU controls from state and IR.
module bus_control_sequencer #(
  parameter int ADDR_W = 12,
  parameter int SC_W   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [15:0]     ir,
  input  logic            e_flag,
  input  logic            ac_zero,
  input  logic            ac_neg,
  input  logic            dr_zero,
  output logic [2:0]      bus_sel,
  output logic            ld_ar,
  output logic            ld_pc,
  output logic            ld_ir,
  output logic            ld_dr,
  output logic            ld_ac,
  output logic            ld_e,
  output logic            inr_ar,
  output logic            inr_pc,
  output logic            inr_dr,
  output logic            inr_ac,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic [3:0]      alu_op,
  output logic            busy,
  output logic            halted,
  output logic [SC_W-1:0] t_count
);

  // state  | meaning
  // IDLE   | out of reset, waiting for start
  // FETCH0 | AR <- PC
  // FETCH1 | IR <- M[AR], PC++
  // DECODE | AR <- IR address field, pick path
  // INDIR  | AR <- M[AR]
  // EXEC0  | first memory-reference execute cycle
  // EXEC1  | second execute cycle
  // EXEC2  | third execute cycle (ISZ write-back)
  // REGIO  | register-reference or I/O instruction
  // HALT   | stopped by HLT, waiting for start
  typedef enum logic [3:0] {
    IDLE, FETCH0, FETCH1, DECODE, INDIR, EXEC0, EXEC1, EXEC2, REGIO, HALT
  } state_t;

  localparam logic [2:0] BUS_NONE = 3'd0;
  localparam logic [2:0] BUS_AR   = 3'd1;
  localparam logic [2:0] BUS_PC   = 3'd2;
  localparam logic [2:0] BUS_DR   = 3'd3;
  localparam logic [2:0] BUS_AC   = 3'd4;
  localparam logic [2:0] BUS_IR   = 3'd5;
  localparam logic [2:0] BUS_MEM  = 3'd7;

  localparam logic [SC_W-1:0] SC_ONE = {{(SC_W-1){1'b0}}, 1'b1};
  localparam logic [SC_W-1:0] SC_MAX = {SC_W{1'b1}};

  state_t              state, state_next;
  logic                ind;
  logic [2:0]          opcode;
  logic [ADDR_W-1:0]   ref_bits;
  logic                running;

  assign ind      = ir[15];
  assign opcode   = ir[14:12];
  assign ref_bits = ir[ADDR_W-1:0];
  assign running  = (state != IDLE) && (state != HALT);
  assign busy     = running;
  assign halted   = (state == HALT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      t_count <= '0;
    end else begin
      state <= state_next;
      if (state_next == FETCH0)
        t_count <= '0;
      else if (running && (t_count != SC_MAX))
        t_count <= t_count + SC_ONE;
    end
  end

  always_comb begin
    state_next = state;
    bus_sel    = BUS_NONE;
    ld_ar      = 1'b0;
    ld_pc      = 1'b0;
    ld_ir      = 1'b0;
    ld_dr      = 1'b0;
    ld_ac      = 1'b0;
    ld_e       = 1'b0;
    inr_ar     = 1'b0;
    inr_pc     = 1'b0;
    inr_dr     = 1'b0;
    inr_ac     = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    alu_op     = 4'b0000;
    case (state)
      IDLE, HALT: if (start) state_next = FETCH0;
      FETCH0: begin
        bus_sel    = BUS_PC;
        ld_ar      = 1'b1;
        state_next = FETCH1;
      end
      FETCH1: begin
        mem_rd     = 1'b1;
        bus_sel    = BUS_MEM;
        ld_ir      = 1'b1;
        inr_pc     = 1'b1;
        state_next = DECODE;
      end
      DECODE: begin
        if (opcode == 3'b111) begin
          state_next = REGIO;
        end else begin
          bus_sel    = BUS_IR;
          ld_ar      = 1'b1;
          state_next = ind ? INDIR : EXEC0;
        end
      end
      INDIR: begin
        mem_rd     = 1'b1;
        bus_sel    = BUS_MEM;
        ld_ar      = 1'b1;
        state_next = EXEC0;
      end
      EXEC0: begin
        state_next = FETCH0;
        case (opcode)
          3'b000, 3'b001, 3'b010, 3'b110: begin
            mem_rd     = 1'b1;
            bus_sel    = BUS_MEM;
            ld_dr      = 1'b1;
            state_next = EXEC1;
          end
          3'b011: begin
            bus_sel = BUS_AC;
            mem_wr  = 1'b1;
          end
          3'b100: begin
            bus_sel = BUS_AR;
            ld_pc   = 1'b1;
          end
          3'b101: begin
            bus_sel    = BUS_PC;
            mem_wr     = 1'b1;
            inr_ar     = 1'b1;
            state_next = EXEC1;
          end
          default: ;
        endcase
      end
      EXEC1: begin
        state_next = FETCH0;
        case (opcode)
          3'b000: begin alu_op = 4'b0000; ld_ac = 1'b1; end
          3'b001: begin alu_op = 4'b0001; ld_ac = 1'b1; ld_e = 1'b1; end
          3'b010: begin alu_op = 4'b0010; ld_ac = 1'b1; end
          3'b101: begin bus_sel = BUS_AR; ld_pc = 1'b1; end
          3'b110: begin inr_dr = 1'b1; state_next = EXEC2; end
          default: ;
        endcase
      end
      EXEC2: begin
        bus_sel    = BUS_DR;
        mem_wr     = 1'b1;
        inr_pc     = dr_zero;
        state_next = FETCH0;
      end
      REGIO: begin
        state_next = FETCH0;
        // Only the most significant set bit of the address field takes effect.
        if (ind) begin
          if (ref_bits[11]) begin alu_op = 4'b0110; ld_ac = 1'b1; end
        end else begin
          casez (ref_bits[11:0])
            12'b1???????????: begin alu_op = 4'b1111; ld_ac = 1'b1; end
            12'b01??????????: begin alu_op = 4'b1000; ld_e  = 1'b1; end
            12'b001?????????: begin alu_op = 4'b0011; ld_ac = 1'b1; end
            12'b0001????????: begin alu_op = 4'b0111; ld_e  = 1'b1; end
            12'b00001???????: begin alu_op = 4'b0100; ld_ac = 1'b1; ld_e = 1'b1; end
            12'b000001??????: begin alu_op = 4'b0101; ld_ac = 1'b1; ld_e = 1'b1; end
            12'b0000001?????: inr_ac = 1'b1;
            12'b00000001????: inr_pc = ~ac_neg;
            12'b000000001???: inr_pc = ac_neg;
            12'b0000000001??: inr_pc = ac_zero;
            12'b00000000001?: inr_pc = ~e_flag;
            12'b000000000001: state_next = HALT;
            default: ;
          endcase
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
